// File: rtl/blake2_msg_sched.sv
// blake2_msg_sched: sequences one blake2 core through a whole hash job.
// Slices the upstream byte stream into BLOCK_BYTES blocks and zero-pads the tail.
// Drives the core's block/first/last/ll/kk/nn inputs, then forwards the nn digest
// bytes with a done pulse.
module blake2_msg_sched #(
    parameter int BLOCK_BYTES = 64,
    parameter int IDX_W       = 7,
    parameter int LL_W        = 128,
    parameter int NN_W        = 6,
    parameter int MAX_NN      = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start_i,
    input  logic [NN_W-1:0]  kk_i,
    input  logic [NN_W-1:0]  nn_i,
    input  logic [LL_W-1:0]  len_i,
    output logic             busy_o,
    output logic             err_o,
    input  logic             msg_v_i,
    input  logic [7:0]       msg_i,
    output logic             msg_ready_o,
    input  logic             core_ready_i,
    output logic             core_data_v_o,
    output logic [IDX_W-1:0] core_data_idx_o,
    output logic [7:0]       core_data_o,
    output logic             core_first_o,
    output logic             core_last_o,
    output logic             core_slow_o,
    output logic [NN_W-1:0]  core_kk_o,
    output logic [NN_W-1:0]  core_nn_o,
    output logic [LL_W-1:0]  core_ll_o,
    input  logic             core_h_v_i,
    input  logic [7:0]       core_h_i,
    output logic             hash_v_o,
    output logic [7:0]       hash_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FEED, S_PAD, S_GAP, S_WAIT_RDY, S_HASH_SKIP, S_HASH, S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [LL_W-1:0]  BLK_LL   = LL_W'(BLOCK_BYTES);
    localparam logic [NN_W-1:0]  MAX_NN_W = NN_W'(MAX_NN);

    state_t           state_q, state_d;
    logic [NN_W-1:0]  kk_q, kk_d, nn_q, nn_d, hcnt_q, hcnt_d;
    logic [LL_W-1:0]  ll_q, ll_d, rem_q, rem_d, nblk_q, nblk_d, blk_q, blk_d;
    logic [IDX_W-1:0] idx_q, idx_d, data_idx_q, data_idx_d;
    logic             gap_q, gap_d;
    logic             data_v_q, data_v_d, first_q, first_d, last_q, last_d;
    logic [7:0]       data_q, data_d, hash_q, hash_d;
    logic             hash_v_q, hash_v_d, done_q, done_d, err_q, err_d;

    logic             msg_ready, xfer, start_ok;
    logic [LL_W-1:0]  start_ll, start_q_blk, start_r_blk, start_nblk;

    // Job descriptor decode: total length (key block included) and block count
    always_comb begin
        start_ll    = len_i + ((kk_i != '0) ? BLK_LL : '0);
        start_q_blk = start_ll / BLK_LL;
        start_r_blk = start_ll % BLK_LL;
        start_nblk  = start_q_blk + ((start_r_blk != '0) ? LL_W'(1) : '0);
        if (start_ll == '0) start_nblk = LL_W'(1);
        start_ok    = (nn_i != '0) && (nn_i <= MAX_NN_W) && (kk_i <= MAX_NN_W);
        msg_ready   = (state_q == S_FEED) && (rem_q != '0) && core_ready_i;
        xfer        = msg_ready && msg_v_i;
    end

    // Next-state and registered-output logic for the job sequencer
    always_comb begin
        state_d    = state_q;
        kk_d       = kk_q;
        nn_d       = nn_q;
        ll_d       = ll_q;
        rem_d      = rem_q;
        nblk_d     = nblk_q;
        blk_d      = blk_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        hcnt_d     = hcnt_q;
        data_v_d   = 1'b0;
        data_idx_d = data_idx_q;
        data_d     = data_q;
        hash_v_d   = 1'b0;
        hash_d     = hash_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (start_ok) begin
                        kk_d    = kk_i;
                        nn_d    = nn_i;
                        ll_d    = start_ll;
                        rem_d   = start_ll;
                        nblk_d  = start_nblk;
                        blk_d   = '0;
                        idx_d   = '0;
                        gap_d   = 1'b0;
                        hcnt_d  = '0;
                        state_d = S_FEED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FEED: begin
                if (rem_q == '0) begin
                    // empty message: the single block is all padding
                    state_d = S_PAD;
                end else if (xfer) begin
                    data_v_d   = 1'b1;
                    data_idx_d = idx_q;
                    data_d     = msg_i;
                    rem_d      = rem_q - LL_W'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        gap_d   = 1'b0;
                        state_d = S_GAP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (rem_q == LL_W'(1)) state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                data_v_d   = 1'b1;
                data_idx_d = idx_q;
                data_d     = 8'h00;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    gap_d   = 1'b0;
                    state_d = S_GAP;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_GAP: begin
                // core_ready_i is stale for two cycles after the final byte
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = S_WAIT_RDY;
                end else begin
                    gap_d = 1'b1;
                end
            end
            S_WAIT_RDY: begin
                if (core_ready_i) begin
                    if (blk_q == nblk_q - LL_W'(1)) begin
                        state_d = S_HASH_SKIP;
                    end else begin
                        blk_d   = blk_q + LL_W'(1);
                        state_d = S_FEED;
                    end
                end
            end
            S_HASH_SKIP: begin
                // the core asserts h_v one cycle before real digest bytes
                if (core_h_v_i) begin
                    hcnt_d  = '0;
                    state_d = S_HASH;
                end
            end
            S_HASH: begin
                if (core_h_v_i) begin
                    hash_v_d = 1'b1;
                    hash_d   = core_h_i;
                    if (hcnt_q == nn_q - NN_W'(1)) state_d = S_DONE;
                    else                           hcnt_d  = hcnt_q + NN_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // block flags follow the block counter and stay flat within a block
        first_d = (state_d != S_IDLE) && (blk_d == '0);
        last_d  = (state_d != S_IDLE) && (blk_d == nblk_d - LL_W'(1));
    end

    // State and output registers, cleared asynchronously on nreset
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            kk_q       <= '0;
            nn_q       <= '0;
            ll_q       <= '0;
            rem_q      <= '0;
            nblk_q     <= '0;
            blk_q      <= '0;
            idx_q      <= '0;
            gap_q      <= 1'b0;
            hcnt_q     <= '0;
            data_v_q   <= 1'b0;
            data_idx_q <= '0;
            data_q     <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            hash_v_q   <= 1'b0;
            hash_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kk_q       <= kk_d;
            nn_q       <= nn_d;
            ll_q       <= ll_d;
            rem_q      <= rem_d;
            nblk_q     <= nblk_d;
            blk_q      <= blk_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            hcnt_q     <= hcnt_d;
            data_v_q   <= data_v_d;
            data_idx_q <= data_idx_d;
            data_q     <= data_d;
            first_q    <= first_d;
            last_q     <= last_d;
            hash_v_q   <= hash_v_d;
            hash_q     <= hash_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy_o          = (state_q != S_IDLE);
    assign err_o           = err_q;
    assign msg_ready_o     = msg_ready;
    assign core_data_v_o   = data_v_q;
    assign core_data_idx_o = data_idx_q;
    assign core_data_o     = data_q;
    assign core_first_o    = first_q;
    assign core_last_o     = last_q;
    assign core_slow_o     = 1'b0;
    assign core_kk_o       = kk_q;
    assign core_nn_o       = nn_q;
    assign core_ll_o       = ll_q;
    assign hash_v_o        = hash_v_q;
    assign hash_o          = hash_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_blake2_msg_sched.sv
// Scoreboard bench for blake2_msg_sched with a behavioural core stub.
module tb_blake2_msg_sched;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         start_i = 1'b0;
    logic [5:0]   kk_i = '0, nn_i = '0;
    logic [127:0] len_i = '0;
    logic         busy_o, err_o;
    logic         msg_v_i, msg_ready_o;
    logic [7:0]   msg_i;
    logic         core_ready_i;
    logic         core_data_v_o;
    logic [6:0]   core_data_idx_o;
    logic [7:0]   core_data_o;
    logic         core_first_o, core_last_o, core_slow_o;
    logic [5:0]   core_kk_o, core_nn_o;
    logic [127:0] core_ll_o;
    logic         core_h_v_i;
    logic [7:0]   core_h_i;
    logic         hash_v_o;
    logic [7:0]   hash_o;
    logic         done_o;

    blake2_msg_sched dut (
        .clk(clk), .nreset(nreset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
        .len_i(len_i), .busy_o(busy_o), .err_o(err_o), .msg_v_i(msg_v_i),
        .msg_i(msg_i), .msg_ready_o(msg_ready_o), .core_ready_i(core_ready_i),
        .core_data_v_o(core_data_v_o), .core_data_idx_o(core_data_idx_o),
        .core_data_o(core_data_o), .core_first_o(core_first_o),
        .core_last_o(core_last_o), .core_slow_o(core_slow_o),
        .core_kk_o(core_kk_o), .core_nn_o(core_nn_o), .core_ll_o(core_ll_o),
        .core_h_v_i(core_h_v_i), .core_h_i(core_h_i), .hash_v_o(hash_v_o),
        .hash_o(hash_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] idx;
        logic [7:0] data;
        logic       first;
        logic       last;
    } cb_t;

    cb_t          exp_core[$];
    logic [7:0]   exp_hash[$];
    logic [7:0]   up_q[$];
    logic [7:0]   msg_buf[$];
    logic [7:0]   stub_dig[0:31];
    int           stub_nn = 32;
    int           tests = 0, fails = 0;
    bit           stall = 1'b0, tog = 1'b0;
    bit           done_seen = 1'b0, saw_blk1 = 1'b0;
    logic [127:0] exp_ll = '0;
    cb_t          mon_e;
    logic [7:0]   mon_h;
    int           seq = 0, hstep = 0, k = 0;
    logic [255:0] dig;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // upstream source: one byte per cycle, or every other cycle when stalling
    initial begin
        msg_v_i = 1'b0;
        msg_i   = '0;
        forever begin
            @(negedge clk);
            tog = ~tog;
            if (nreset && up_q.size() > 0 && (!stall || tog)) begin
                msg_v_i = 1'b1;
                msg_i   = up_q[0];
                #1;
                if (msg_ready_o) void'(up_q.pop_front());
            end else begin
                msg_v_i = 1'b0;
                msg_i   = '0;
            end
        end
    end

    // core stub: drops ready for 4 cycles one cycle after each block, then after
    // the last block emits one junk h_v byte followed by the stub digest
    initial begin
        core_ready_i = 1'b1;
        core_h_v_i   = 1'b0;
        core_h_i     = '0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                core_ready_i = 1'b1;
                core_h_v_i   = 1'b0;
                core_h_i     = '0;
                seq          = 0;
                hstep        = 0;
            end else begin
                if (seq != 0) begin
                    if (seq == 5) begin core_ready_i = 1'b1; seq = 0; end
                    else begin core_ready_i = 1'b0; seq++; end
                end
                if (hstep != 0) begin
                    k = hstep - 10;
                    if (k > stub_nn) begin
                        core_h_v_i = 1'b0;
                        hstep      = 0;
                    end else begin
                        if (k >= 0) begin
                            core_h_v_i = 1'b1;
                            core_h_i   = (k == 0) ? 8'hEE : stub_dig[k-1];
                        end
                        hstep++;
                    end
                end
                if (core_data_v_o && core_data_idx_o == 7'd63) begin
                    seq = 1;
                    if (core_last_o) hstep = 1;
                end
            end
        end
    end

    // monitor: pops and compares whenever the DUT presents a byte
    initial begin
        forever begin
            @(negedge clk);
            if (nreset) begin
                if (core_data_v_o) begin
                    if (!core_first_o) saw_blk1 = 1'b1;
                    if (exp_core.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL core_extra: got idx %0d data %0h, expected no byte",
                                 core_data_idx_o, core_data_o);
                    end else begin
                        mon_e = exp_core.pop_front();
                        check("core_byte{idx,data,first,last}",
                              {core_data_idx_o, core_data_o, core_first_o, core_last_o}, mon_e);
                    end
                    if (core_data_idx_o == 7'd63) check("msg_ready_in_gap", msg_ready_o, 0);
                end
                if (hash_v_o) begin
                    if (exp_hash.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL hash_extra: got %0h, expected no byte", hash_o);
                    end else begin
                        mon_h = exp_hash.pop_front();
                        check("hash_byte", hash_o, mon_h);
                    end
                end
                if (done_o) begin
                    done_seen = 1'b1;
                    check("done_after_digest", exp_hash.size(), 0);
                end
            end
        end
    end

    task automatic load_dig(input logic [255:0] d);
        for (int i = 0; i < 32; i++) stub_dig[i] = d[255-8*i -: 8];
    endtask

    task automatic load_pat(input logic [7:0] seed);
        for (int i = 0; i < 32; i++) stub_dig[i] = seed + 8'(i * 7);
    endtask

    task automatic fill_msg(input int n, input logic [7:0] seed);
        msg_buf.delete();
        for (int i = 0; i < n; i++) msg_buf.push_back(seed + 8'(i * 3));
    endtask

    task automatic start_job(input logic [5:0] kk, input logic [5:0] nn, input logic [127:0] len);
        logic [127:0] ll;
        int           nblk, pos;
        cb_t          e;
        ll   = len + ((kk != 0) ? 128'd64 : 128'd0);
        nblk = (ll == 0) ? 1 : int'((ll + 128'd63) / 128'd64);
        exp_ll = ll;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 64; i++) begin
                pos     = b * 64 + i;
                e.idx   = 7'(i);
                e.data  = (128'(pos) < ll) ? msg_buf[pos] : 8'h00;
                e.first = (b == 0);
                e.last  = (b == nblk - 1);
                exp_core.push_back(e);
            end
        end
        stub_nn = int'(nn);
        for (int i = 0; i < int'(nn); i++) exp_hash.push_back(stub_dig[i]);
        foreach (msg_buf[i]) up_q.push_back(msg_buf[i]);
        done_seen = 1'b0;
        saw_blk1  = 1'b0;
        @(negedge clk);
        start_i = 1'b1; kk_i = kk; nn_i = nn; len_i = len;
        @(negedge clk);
        start_i = 1'b0;
        check("start_busy", busy_o, 1);
        check("start_ll", core_ll_o, ll);
        check("start_kk_nn", {core_kk_o, core_nn_o}, {kk, nn});
    endtask

    task automatic finish_job(input string name);
        for (int c = 0; c < 3000 && !done_seen; c++) @(negedge clk);
        check({name, "_done_seen"}, done_seen, 1);
        check({name, "_core_bytes_left"}, exp_core.size(), 0);
        check({name, "_hash_bytes_left"}, exp_hash.size(), 0);
        check({name, "_idle_after_done"}, busy_o, 0);
        check({name, "_ll_held"}, core_ll_o, exp_ll);
        exp_core.delete();
        exp_hash.delete();
        up_q.delete();
    endtask

    task automatic bad_start(input string name, input logic [5:0] kk, input logic [5:0] nn);
        @(negedge clk);
        start_i = 1'b1; kk_i = kk; nn_i = nn; len_i = 128'd10;
        @(negedge clk);
        start_i = 1'b0;
        check({name, "_err"}, err_o, 1);
        check({name, "_busy"}, busy_o, 0);
        @(negedge clk);
        check({name, "_err_pulse"}, err_o, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy_o, err_o, msg_ready_o, core_data_v_o, core_data_idx_o, core_data_o,
               core_first_o, core_last_o, core_slow_o, core_kk_o, core_nn_o, core_ll_o,
               hash_v_o, hash_o, done_o}, 0);
        nreset = 1'b1;
        @(negedge clk);
        check("slow_tied_low", core_slow_o, 0);

        bad_start("nn0", 6'd0, 6'd0);
        bad_start("nn33", 6'd0, 6'd33);
        bad_start("kk33", 6'd33, 6'd16);

        // "abc", unkeyed, 32-byte digest
        msg_buf.delete();
        msg_buf.push_back(8'h61); msg_buf.push_back(8'h62); msg_buf.push_back(8'h63);
        dig = 256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982;
        load_dig(dig);
        start_job(6'd0, 6'd32, 128'd3);
        finish_job("abc");

        // empty message: one all-zero block
        msg_buf.delete();
        dig = 256'h69217a3079908094e11121d042354a7c1f55b6482ca1a51e1b250dfd1ed0eef9;
        load_dig(dig);
        start_job(6'd0, 6'd32, 128'd0);
        finish_job("empty");

        // exactly one full block, short digest
        fill_msg(64, 8'h01);
        load_pat(8'h10);
        start_job(6'd0, 6'd4, 128'd64);
        finish_job("len64");

        // one byte spills into a second, mostly padded block
        fill_msg(65, 8'h40);
        load_pat(8'h33);
        start_job(6'd0, 6'd16, 128'd65);
        finish_job("len65");

        // keyed: key block supplied by upstream, then 3 message bytes
        msg_buf.delete();
        msg_buf.push_back(8'hAA); msg_buf.push_back(8'hBB);
        msg_buf.push_back(8'hCC); msg_buf.push_back(8'hDD);
        for (int i = 0; i < 60; i++) msg_buf.push_back(8'h00);
        msg_buf.push_back(8'h78); msg_buf.push_back(8'h79); msg_buf.push_back(8'h7A);
        load_pat(8'h90);
        start_job(6'd4, 6'd20, 128'd3);
        finish_job("keyed");

        // upstream stalls every other cycle; a second start while busy is ignored
        stall = 1'b1;
        fill_msg(130, 8'h05);
        load_pat(8'h5A);
        start_job(6'd0, 6'd32, 128'd130);
        repeat (20) @(negedge clk);
        start_i = 1'b1; kk_i = 6'd1; nn_i = 6'd5; len_i = 128'd9;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_start_kk_nn", {core_kk_o, core_nn_o}, {6'd0, 6'd32});
        check("busy_start_ll", core_ll_o, 128'd130);
        check("busy_start_err", err_o, 0);
        finish_job("stall130");
        stall = 1'b0;

        // reset in the middle of block 1 aborts the job
        fill_msg(130, 8'h21);
        load_pat(8'h70);
        start_job(6'd0, 6'd32, 128'd130);
        for (int c = 0; c < 400 && !saw_blk1; c++) @(negedge clk);
        check("reached_block1", saw_blk1, 1);
        #2 nreset = 1'b0;
        #1;
        check("midjob_reset_outputs",
              {busy_o, err_o, msg_ready_o, core_data_v_o, core_data_idx_o, core_data_o,
               core_first_o, core_last_o, core_slow_o, core_kk_o, core_nn_o, core_ll_o,
               hash_v_o, hash_o, done_o}, 0);
        exp_core.delete();
        exp_hash.delete();
        up_q.delete();
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        msg_buf.delete();
        msg_buf.push_back(8'h61); msg_buf.push_back(8'h62); msg_buf.push_back(8'h63);
        dig = 256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982;
        load_dig(dig);
        start_job(6'd0, 6'd32, 128'd3);
        finish_job("abc_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blake2_msg_sched.md
Name: blake2_msg_sched

Overview:
- Front-end controller that sequences one blake2 core instance for a whole hash job.
- Accepts a job descriptor and an upstream byte stream.
- Slices the stream into BLOCK_BYTES blocks and zero-pads the final block.
- Drives the core's data/index/first/last/ll/kk/nn inputs and honours the core's ready, then collects the nn digest bytes into a clean output stream with a done pulse.
- Sits between the host/PIO byte interface and the core.

Parameters:
- BLOCK_BYTES, 64: bytes per compression block; the core computes on data_idx == BLOCK_BYTES-1.
- IDX_W, 7: core data_idx width.
- LL_W, 128: core ll input width; the message length counter is LL_W bits.
- NN_W, 6: kk/nn width.
- MAX_NN, 32: largest legal digest length.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- start_i  in  1  job start pulse; sampled in IDLE only
- kk_i  in  NN_W  key length; nonzero means upstream sends the key zero-padded to one full block first
- nn_i  in  NN_W  digest length, 1..MAX_NN
- len_i  in  LL_W  message length in bytes, key block excluded
- busy_o  out  1  job in progress
- err_o  out  1  one-cycle pulse on an illegal start
- msg_v_i  in  1  upstream byte valid
- msg_i  in  8  upstream byte
- msg_ready_o  out  1  upstream ready; a transfer occurs when msg_v_i & msg_ready_o
- core_ready_i  in  1  core ready_v_o
- core_data_v_o  out  1  core data_v_i
- core_data_idx_o  out  IDX_W  core data_idx_i
- core_data_o  out  8  core data_i
- core_first_o  out  1  block_first_i
- core_last_o  out  1  block_last_i
- core_slow_o  out  1  slow_output_i, tied 0
- core_kk_o  out  NN_W  latched kk
- core_nn_o  out  NN_W  latched nn
- core_ll_o  out  LL_W  latched total length
- core_h_v_i  in  1  core h_v_o
- core_h_i  in  8  core h_o
- hash_v_o  out  1  digest byte valid; no backpressure
- hash_o  out  8  digest byte
- done_o  out  1  one-cycle pulse after the last digest byte

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset asserted mid-job aborts immediately; no partial-job state survives. The core shares nreset.

Job start:
- IDLE with start_i and 1 <= nn_i <= MAX_NN and kk_i <= MAX_NN:
  - latch kk, nn;
  - ll = len_i + (kk != 0 ? BLOCK_BYTES : 0);
  - total = ll;
  - nblk = max(1, ceil(ll / BLOCK_BYTES));
  - go to FEED.
- Otherwise pulse err_o and stay in IDLE.
- start_i outside IDLE is ignored.
- busy_o = (state != IDLE).

FSM states: IDLE, FEED, PAD, GAP, WAIT_RDY, HASH_SKIP, HASH, DONE.

FEED:
- msg_ready_o = 1 while remaining bytes > 0 and core_ready_i.
- Each transfer presents the byte registered on the next cycle: core_data_v_o = 1, core_data_idx_o = idx, and idx increments.
- core_first_o is 1 for every byte of block 0; core_last_o is 1 for every byte of block nblk-1. Both are held constant across a block.
- Remaining bytes reach 0 with idx != 0 → PAD. No bytes at all (ll = 0) → PAD.

PAD:
- Emits 0x00 bytes on consecutive cycles, no upstream transfer, until idx = BLOCK_BYTES-1 has been sent.

End of block:
- After idx BLOCK_BYTES-1 is emitted, idx wraps to 0 and the FSM enters GAP for 2 cycles, ignoring core_ready_i (the core drops ready one cycle after the final byte).
- Then WAIT_RDY until core_ready_i = 1.
- From WAIT_RDY: last block sent → HASH_SKIP; otherwise → FEED with block counter + 1.

Digest collection:
- HASH_SKIP: the first core_h_v_i cycle is discarded (the core raises h_v one cycle early).
- HASH: the next nn cycles with core_h_v_i are forwarded registered: hash_v_o/hash_o one cycle later, one byte per cycle.
- After the nn-th byte → DONE.

DONE:
- done_o = 1 for one cycle → IDLE.

Width and ordering rules:
- Length counters saturate at 0.
- core_ll_o is stable from start through done.
- Digest bytes are output LSB-first, matching core order (h[0] byte 0 first).

Test Plan:
- "abc", kk=0, nn=32, len=3 → core sees 1 block with first = last = 1; bytes 61 62 63 followed by 61 zero bytes; ll=3. hash_o = 50 8C 5E 8C … 86 67 59 82 (BLAKE2s-256 of "abc"); done_o after 32 bytes.
- Empty message, len=0, nn=32 → 1 all-zero block, first = last = 1, ll=0. Digest 69 21 7A 30 … 1E D0 EE F9.
- len=64 → exactly 1 block, no PAD. len=65 → 2 blocks, the second holding 1 data byte plus 63 pad bytes, core_last_o only on block 1.
- Upstream stall: msg_v_i toggling every other cycle on a 130-byte message → core_data_v_o gaps are allowed, indices stay contiguous 0..63, digest matches the golden model; msg_ready_o is 0 during GAP/WAIT_RDY.
- Illegal start: nn_i=0 or nn_i=33 → err_o pulse, busy_o stays 0. start_i while busy → ignored, latched kk/nn/ll unchanged.
- nreset pulsed mid-FEED of block 1 → all outputs 0 asynchronously. A following legal "abc" job completes with the correct digest.
